// File: rtl/apb_rr_master.sv
// Round-robin two-port APB master: SETUP/ACCESS sequencing with a wait-state timeout.
// One transfer at a time, 4 cycles minimum; ready only in IDLE; response is a one-cycle strobe.
module apb_rr_master #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Pclk,
    input  logic              Prst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic              Pselx,
    output logic              Penable,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                gid;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [7:0]          wait_cnt;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                grant_any;
    logic                grant_id;
    logic                timeout_hit;
    logic                active;

    // On a tie the port that did not win last time goes next.
    assign grant_any   = req0_valid | req1_valid;
    assign grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign timeout_hit = !Pready && (wait_cnt == 8'(TIMEOUT - 1));
    assign active      = (state == S_SETUP) || (state == S_ACCESS);

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (grant_any) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: if (Pready || timeout_hit) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            last_grant <= 1'b1;
            gid        <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_id;
                        gid        <= grant_id;
                        lat_write  <= grant_id ? req1_write : req0_write;
                        lat_addr   <= grant_id ? req1_addr  : req0_addr;
                        lat_wdata  <= grant_id ? req1_wdata : req0_wdata;
                    end
                end
                S_SETUP: wait_cnt <= '0;
                S_ACCESS: begin
                    if (Pready) begin
                        err_q   <= Pslverr;
                        rdata_q <= (!lat_write && !Pslverr) ? Prdata : '0;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Everything below is decoded from the state register so reset clears it without a clock.
    assign req0_ready = (state == S_IDLE) && grant_any && !grant_id;
    assign req1_ready = (state == S_IDLE) && grant_any &&  grant_id;

    assign Pselx   = active;
    assign Penable = (state == S_ACCESS);
    assign Paddr   = active ? lat_addr : '0;
    assign Pwrite  = active && lat_write;
    assign Pwdata  = (active && lat_write) ? lat_wdata : '0;

    assign rsp0_valid = (state == S_RESP) && !gid;
    assign rsp1_valid = (state == S_RESP) &&  gid;
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Randomized two-port traffic against a reactive APB slave; scoreboard checks grants, APB phases and responses.
module tb_apb_rr_master;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 15;

    typedef struct {
        int            port;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    typedef struct {
        int   wt;
        logic err;
    } plan_t;

    logic          Pclk = 1'b0;
    logic          Prst;
    logic          rv[2];
    logic          rw[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2];
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata, Prdata;
    logic          Pwrite, Pselx, Penable, Pready, Pslverr;

    apb_rr_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .Pclk(Pclk), .Prst(Prst),
        .req0_valid(rv[0]), .req0_write(rw[0]), .req0_addr(ra[0]), .req0_wdata(rd[0]), .req0_ready(req0_ready),
        .req1_valid(rv[1]), .req1_write(rw[1]), .req1_addr(ra[1]), .req1_wdata(rd[1]), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .Paddr(Paddr), .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
        .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    always #5 Pclk = ~Pclk;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    exp_t          expq[$];
    plan_t         planq[$];
    int            glog[$];
    logic [DW-1:0] ref_mem[32];
    logic [DW-1:0] slv_mem[32];
    bit            last_g = 1'b1;
    bit            busy = 1'b0;
    bit            acc[2];
    bit            prev_sel = 1'b0;
    int            force_wt = -1;
    bit            force_err = 1'b0;
    logic          cur_w = 1'b0;
    logic [AW-1:0] cur_a = '0;
    logic [DW-1:0] cur_d = '0;
    int            s_wt = -1;
    bit            s_err = 1'b0;

    always @(posedge Pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor / reference model: grant rule, APB phase contents, response scoreboard.
    always @(negedge Pclk) begin
        if (!Prst) begin
            if (Penable) chk("penable_needs_setup", {prev_sel, Pselx}, 2'b11);
            if (Pselx) chk("apb_fields", {Paddr, Pwrite, Pwdata}, {cur_a, cur_w, (cur_w ? cur_d : 32'h0)});
            else chk("apb_idle_low", {Paddr, Pwrite, Pwdata, Penable}, '0);
            prev_sel = Pselx;

            if (busy) begin
                chk("ready_while_busy", {req1_ready, req0_ready}, 2'b00);
            end else if (rv[0] || rv[1]) begin
                int   w;
                int   p;
                plan_t pl;
                exp_t  e;
                w = (rv[0] && rv[1]) ? int'(!last_g) : int'(rv[1]);
                chk("grant", {req1_ready, req0_ready}, (w == 1) ? 2'b10 : 2'b01);
                if (req0_ready || req1_ready) begin
                    p = req1_ready ? 1 : 0;
                    last_g = p[0];
                    busy = 1'b1;
                    acc[p] = 1'b1;
                    glog.push_back(p);
                    cur_w = rw[p]; cur_a = ra[p]; cur_d = rd[p];
                    if (force_wt >= 0) begin
                        pl.wt = force_wt; pl.err = force_err;
                    end else begin
                        pl.wt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 3));
                        pl.err = ($urandom_range(0, 7) == 0);
                    end
                    planq.push_back(pl);
                    e.port  = p;
                    e.err   = (pl.wt >= TO) ? 1'b1 : pl.err;
                    e.rdata = (!cur_w && !e.err) ? ref_mem[cur_a] : '0;
                    e.cyc   = cyc + 3 + ((pl.wt >= TO) ? TO - 1 : pl.wt);
                    if (cur_w && !e.err) ref_mem[cur_a] = cur_d;
                    expq.push_back(e);
                end
            end else begin
                chk("ready_without_valid", {req1_ready, req0_ready}, 2'b00);
            end

            if (rsp0_valid || rsp1_valid) begin
                if (expq.size() == 0) begin
                    chk("unexpected_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("rsp_port", {rsp1_valid, rsp0_valid}, (e.port == 1) ? 2'b10 : 2'b01);
                    chk("rsp_rdata", (e.port == 1) ? rsp1_rdata : rsp0_rdata, e.rdata);
                    chk("rsp_err", (e.port == 1) ? rsp1_err : rsp0_err, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_other_quiet", (e.port == 1) ? {rsp0_rdata, rsp0_err} : {rsp1_rdata, rsp1_err}, '0);
                end
                busy = 1'b0;
            end
        end
    end

    // Reactive slave: wait states and error chosen per transfer by the model.
    always @(negedge Pclk) begin
        if (Prst) begin
            Pready = 1'b0; Pslverr = 1'b0; Prdata = '0; s_wt = -1;
        end else if (Pselx && !Penable) begin
            if (planq.size() > 0) begin
                plan_t pl;
                pl = planq.pop_front();
                s_wt = pl.wt; s_err = pl.err;
            end
            Pready = 1'b0; Pslverr = 1'($urandom); Prdata = $urandom;
        end else if (Pselx && Penable) begin
            if (s_wt == 0) begin
                Pready = 1'b1; Pslverr = s_err;
                Prdata = (s_err || Pwrite) ? $urandom : slv_mem[Paddr];
                if (Pwrite && !s_err) slv_mem[Paddr] = Pwdata;
            end else begin
                Pready = 1'b0; Pslverr = 1'($urandom); Prdata = $urandom;
            end
            s_wt = s_wt - 1;
        end else begin
            Pready = 1'($urandom); Pslverr = 1'($urandom); Prdata = $urandom;
        end
    end

    task automatic drive_one(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        acc[p] = 1'b0;
        rv[p] = 1'b1; rw[p] = w; ra[p] = a; rd[p] = d;
        while (!acc[p] && t < 400) begin
            @(posedge Pclk);
            t++;
        end
        chk("accept_in_time", acc[p], 1'b1);
        #1 rv[p] = 1'b0;
    endtask

    task automatic drive_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge Pclk);
                #1;
            end
            drive_one(p, 1'($urandom), AW'($urandom), $urandom);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (busy && t < 500) begin
            @(posedge Pclk);
            t++;
        end
        chk("drain", busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        for (int p = 0; p < 2; p++) begin
            rv[p] = 1'b0; rw[p] = 1'b0; ra[p] = '0; rd[p] = '0; acc[p] = 1'b0;
        end
        Prst = 1'b1;
        repeat (3) @(posedge Pclk);
        @(negedge Pclk);
        chk("reset_apb", {Pselx, Penable, Pwrite, Paddr, Pwdata}, '0);
        chk("reset_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata}, '0);
        chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
        @(posedge Pclk);
        #1 Prst = 1'b0;

        force_wt = 0; force_err = 1'b0;
        drive_one(0, 1'b1, 5'd5, 32'hDEADBEEF);
        drain();
        @(posedge Pclk); #1;
        drive_one(1, 1'b0, 5'd5, 32'h0);
        drain();
        @(posedge Pclk); #1;
        force_wt = 3; force_err = 1'b1;
        drive_one(0, 1'b0, 5'd9, 32'h0);
        drain();
        @(posedge Pclk); #1;
        force_wt = 1000; force_err = 1'b0;
        drive_one(1, 1'b0, 5'd2, 32'h0);
        drain();
        @(posedge Pclk); #1;
        force_wt = 0;
        drive_one(1, 1'b0, 5'd5, 32'h0);
        drain();

        force_wt = -1;
        @(posedge Pclk); #1;
        fork
            drive_port(0, 40);
            drive_port(1, 40);
        join
        drain();

        force_wt = 1000;
        @(posedge Pclk); #1;
        drive_one(0, 1'b1, 5'd7, 32'h12345678);
        begin
            int t = 0;
            while (!Penable && t < 50) begin
                @(negedge Pclk);
                t++;
            end
        end
        chk("penable_before_reset", Penable, 1'b1);
        #2 Prst = 1'b1;
        #1 chk("async_reset_drops_apb", {Pselx, Penable, Paddr}, '0);
        expq.delete(); planq.delete(); glog.delete();
        busy = 1'b0; last_g = 1'b1;
        repeat (2) @(posedge Pclk);
        #1 Prst = 1'b0;
        force_wt = 0;
        fork
            drive_one(0, 1'b0, 5'd7, 32'h0);
            drive_one(1, 1'b0, 5'd5, 32'h0);
        join
        drain();
        chk("post_reset_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);
        repeat (3) @(posedge Pclk);
        chk("scoreboard_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-port APB master that shares the single-slave APB word memory between two requesters (e.g. a CPU-side port and a DMA/test port).
- Arbitrates round-robin, sequences the APB SETUP/ACCESS phases, waits on Pready, and returns read data and error status to the winning requester.
- Sits directly in front of the memory slave; it is the only driver of that slave's Pselx/Penable/Pwrite/Paddr/Pwdata.

Parameters:
- ADDR_W, 5, APB word address width (32-word memory).
- DATA_W, 32, data width.
- TIMEOUT, 15, max ACCESS cycles without Pready before the transfer is aborted with error; legal range 1..255.

Ports:
- Pclk in 1 system clock, all logic on rising edge.
- Prst in 1 reset, asynchronous, active-high.
- req0_valid / req1_valid in 1 request pending on port N.
- req0_write / req1_write in 1 1=write, 0=read.
- req0_addr / req1_addr in ADDR_W word address.
- req0_wdata / req1_wdata in DATA_W write data.
- req0_ready / req1_ready out 1 combinational accept; transfer taken at an edge where valid&ready.
- rsp0_valid / rsp1_valid out 1 one-cycle response strobe.
- rsp0_rdata / rsp1_rdata out DATA_W read data, valid with strobe (0 for writes and errors).
- rsp0_err / rsp1_err out 1 Pslverr or timeout, valid with strobe.
- Paddr out ADDR_W; Pwdata out DATA_W; Pwrite out 1; Pselx out 1; Penable out 1: APB master outputs.
- Prdata in DATA_W; Pready in 1; Pslverr in 1: APB slave returns.

Behaviour:
- Reset (async, immediate): state=IDLE, last_grant=1 (port 0 wins first tie), all APB outputs 0, all rsp outputs 0, wait counter 0. Reset mid-transfer abandons it; no response is issued.
- States: IDLE, SETUP, ACCESS, RESP (registered FSM).
- IDLE: if exactly one valid, that port is granted. If both are valid, the port not equal to last_grant is granted. reqN_ready=1 only for the granted port, only in IDLE; at that edge latch write/addr/wdata and grant id, set last_grant, go to SETUP. No valid: stay.
- SETUP (1 cycle): Pselx=1, Penable=0, Paddr/Pwrite/Pwdata from the latch (Pwdata=0 on reads). Then go to ACCESS. Wait counter cleared.
- ACCESS: Pselx=1, Penable=1, address/control stable.
  - Pready=1 at edge: capture err=Pslverr; rdata=Prdata if read and !Pslverr, else 0. Go to RESP.
  - Pready=0: counter+1. When counter reaches TIMEOUT with Pready still 0, capture err=1, rdata=0, go to RESP.
- RESP (1 cycle): Pselx=Penable=0; rspN_valid=1 for the granted port only; rdata/err driven. Other port's rsp outputs are 0. Then IDLE.
- Minimum latency: accept edge E0 -> SETUP cycle -> ACCESS cycle (Pready sampled at E2) -> rsp strobe in cycle after E2. 4 cycles per transfer; no back-to-back pipelining.
- Requests arriving outside IDLE are not accepted; requester holds valid until ready.
- APB outputs are idle-low between transfers.
- The APB protocol rule holds: Penable never rises without a preceding Pselx-only cycle.
- No address decode: every ADDR_W value is forwarded; range errors come only via Pslverr.

Test Plan:
- Port0 write addr 5 data 0xDEADBEEF, Pready tied 1 -> SETUP then ACCESS with Paddr=5, Pwrite=1; rsp0_valid one cycle later with err=0; 4 cycles total.
- Port1 read addr 5, slave returns Prdata=0xDEADBEEF on first ACCESS -> rsp1_rdata=0xDEADBEEF, rsp1_err=0, rsp0_valid stays 0.
- Both ports valid continuously, 4 transfers -> grant order 0,1,0,1; each req_ready pulses only in IDLE.
- Slave holds Pready=0 for 3 ACCESS cycles, then Pready=1 with Pslverr=1 on a read -> Penable stays high 4 cycles; rsp err=1, rdata=0.
- Pready never asserted, TIMEOUT=15 -> abort after 15 ACCESS cycles; rsp err=1; FSM back to IDLE; next request proceeds normally.
- Prst asserted during ACCESS -> Pselx/Penable drop the same cycle with no clock edge needed; no rsp strobe; after release, port 0 wins a simultaneous request.
